// File: rtl/riscv_mem_arb.sv
// Shares one single-port synchronous RAM between instruction fetch and the data port.
// Data wins by default; a starvation counter hands fetch one slot after STARVE_LIMIT data wins.
module riscv_mem_arb #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sft_rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // Handshake: a requester holds req and its payload until it samples gnt high at a
  // rising edge; it may present a new request in the very next cycle.

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic                 i_rvalid_q, i_rvalid_d;
  logic                 d_rvalid_q, d_rvalid_d;
  logic                 starve;
  logic                 in_reset;

  always_comb begin
    in_reset  = rst | sft_rst;
    starve    = i_req & (starve_cnt_q == CNT_MAX);
    d_gnt     = d_req & ~starve & ~in_reset;
    i_gnt     = i_req & ~d_gnt & ~in_reset;
    ram_cs    = i_gnt | d_gnt;
    ram_we    = d_gnt & d_we;
    ram_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
    ram_wdata = ram_cs ? d_wdata : '0;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    i_rvalid_d   = i_gnt;
    d_rvalid_d   = d_gnt & ~d_we;
    if (sft_rst) begin
      starve_cnt_d = '0;
      i_rvalid_d   = 1'b0;
      d_rvalid_d   = 1'b0;
    end else if (i_gnt || !i_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      i_rvalid_q   <= i_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  // A response owed from the cycle before a soft reset is suppressed, not delivered late.
  assign i_rvalid = i_rvalid_q & ~sft_rst;
  assign d_rvalid = d_rvalid_q & ~sft_rst;
  assign rdata    = ram_rdata;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Bench for riscv_mem_arb: directed scenarios plus a randomized run against a
// transaction-level model (grant choice, shadow memory, expected read-data queue).
module tb_riscv_mem_arb;

  localparam int AW  = 14;
  localparam int DW  = 64;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst, sft_rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int tests_run = 0;
  int failures  = 0;

  riscv_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .sft_rst(sft_rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Power-up RAM contents are a fixed function of the address.
  function automatic logic [DW-1:0] init_val(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'(a) ^ 32'h5A5A_5A5A};
  endfunction

  // RAM stub: 1-cycle read latency, read data held until the next read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit            ram_wr [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        ram[ram_addr]    <= ram_wdata;
        ram_wr[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= ram_wr[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
      end
    end
  end

  // Reference model state
  int            m_cnt;          // data wins since fetch last got served while fetch waited
  logic [DW-1:0] m_mem [int];
  bit            exp_i, exp_d;
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] m_read(input int a);
    return m_mem.exists(a) ? m_mem[a] : init_val(a);
  endfunction

  // 0 = nobody, 1 = fetch, 2 = data
  function automatic int pick();
    if (rst || sft_rst) return 0;
    if (d_req && !(i_req && m_cnt >= LIM)) return 2;
    if (i_req) return 1;
    return 0;
  endfunction

  task automatic commit(input int g);
    if (sft_rst) begin
      m_cnt = 0; exp_i = 0; exp_d = 0;
      return;
    end
    exp_i = (g == 1);
    exp_d = (g == 2) && !d_we;
    if (exp_i) exp_q.push_back(m_read(int'(i_addr)));
    if (exp_d) exp_q.push_back(m_read(int'(d_addr)));
    if (g == 2 && d_we) m_mem[int'(d_addr)] = d_wdata;
    if (g == 1 || !i_req) m_cnt = 0;
    else if (g == 2 && m_cnt < LIM) m_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_req = 0; d_req = 0; d_we = 0; sft_rst = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_req = 1; i_addr = 14'h030; d_req = 1; d_we = 0; d_addr = 14'h020;
    @(negedge clk);
    @(posedge clk); #3;
    tests_run++;
    if (d_rvalid !== 1'b1 || dut.starve_cnt_q !== 3'd2) begin
      failures++; $display("FAIL pre_reset_state: got rvalid=%b cnt=%0d want rvalid=1 cnt=2", d_rvalid, dut.starve_cnt_q);
    end
    rst = 1; #1;
    tests_run++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || dut.starve_cnt_q !== 3'd0) begin
      failures++; $display("FAIL async_reset: got i_rv=%b d_rv=%b cnt=%0d want 0 0 0", i_rvalid, d_rvalid, dut.starve_cnt_q);
    end
    tests_run++;
    if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || ram_cs !== 1'b0) begin
      failures++; $display("FAIL reset_no_grant: got i_gnt=%b d_gnt=%b cs=%b want 0 0 0", i_gnt, d_gnt, ram_cs);
    end
    @(negedge clk);
    rst = 0; i_req = 0; d_req = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      tests_run++;
      if (ram_cs !== 1'b0 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        failures++; $display("FAIL idle_cycle%0d: got cs=%b i_rv=%b d_rv=%b want 0 0 0", k, ram_cs, i_rvalid, d_rvalid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin i_req = 1; i_addr = AW'(16 + k); end
      else i_req = 0;
      #1;
      if (k < 3) begin
        tests_run++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AW'(16 + k)) begin
          failures++; $display("FAIL fetch_grant%0d: got gnt=%b cs=%b we=%b addr=%h want 1 1 0 %h", k, i_gnt, ram_cs, ram_we, ram_addr, 16 + k);
        end
      end
      if (k > 0) begin
        tests_run++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || rdata !== init_val(15 + k)) begin
          failures++; $display("FAIL fetch_data%0d: got rv=%b rdata=%h want rv=1 rdata=%h", k - 1, i_rvalid, rdata, init_val(15 + k));
        end
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if (i_rvalid !== 1'b0) begin
      failures++; $display("FAIL fetch_tail: got i_rvalid=%b want 0", i_rvalid);
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 14'h100; d_wdata = 64'hDEADBEEF_CAFEF00D; #1;
    tests_run++;
    if (d_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 14'h100 || ram_wdata !== 64'hDEADBEEF_CAFEF00D) begin
      failures++; $display("FAIL store_drive: got gnt=%b we=%b addr=%h wdata=%h", d_gnt, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    d_we = 0; #1;
    tests_run++;
    if (d_gnt !== 1'b1 || ram_we !== 1'b0 || d_rvalid !== 1'b0) begin
      failures++; $display("FAIL load_drive: got gnt=%b we=%b d_rvalid=%b want 1 0 0", d_gnt, ram_we, d_rvalid);
    end
    @(negedge clk);
    d_req = 0; #1;
    tests_run++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || rdata !== 64'hDEADBEEF_CAFEF00D) begin
      failures++; $display("FAIL load_data: got rv=%b rdata=%h want rv=1 rdata=deadbeefcafef00d", d_rvalid, rdata);
    end
    @(negedge clk); #1;
    tests_run++;
    if (d_rvalid !== 1'b0) begin
      failures++; $display("FAIL load_tail: got d_rvalid=%b want 0", d_rvalid);
    end
  endtask

  task automatic test_contention();
    bit            want_d;
    logic [AW-1:0] want_addr;
    idle(2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_req = 1; i_addr = 14'h040; d_req = 1; d_we = 0; d_addr = 14'h050; #1;
      want_d    = (k % (LIM + 1)) != LIM;
      want_addr = want_d ? 14'h050 : 14'h040;
      tests_run++;
      if (d_gnt !== want_d || i_gnt !== !want_d || ram_addr !== want_addr || dut.starve_cnt_q !== 3'(k % (LIM + 1))) begin
        failures++; $display("FAIL contention%0d: got d=%b i=%b addr=%h cnt=%0d want d=%b cnt=%0d", k, d_gnt, i_gnt, ram_addr, dut.starve_cnt_q, want_d, k % (LIM + 1));
      end
    end
    idle(2);
  endtask

  task automatic test_collision();
    @(negedge clk);
    i_req = 1; i_addr = 14'h060; d_req = 1; d_we = 1; d_addr = 14'h070; d_wdata = 64'h1234; #1;
    tests_run++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || ram_addr !== 14'h070 || ram_we !== 1'b1) begin
      failures++; $display("FAIL collision_data_wins: got d=%b i=%b addr=%h we=%b", d_gnt, i_gnt, ram_addr, ram_we);
    end
    @(negedge clk);
    d_req = 0; #1;
    tests_run++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || ram_addr !== 14'h060) begin
      failures++; $display("FAIL collision_fetch_next: got i=%b d=%b addr=%h want 1 0 060", i_gnt, d_gnt, ram_addr);
    end
    @(negedge clk);
    i_req = 0; #1;
    tests_run++;
    if (i_rvalid !== 1'b1 || rdata !== init_val(32'h60)) begin
      failures++; $display("FAIL collision_fetch_data: got rv=%b rdata=%h want 1 %h", i_rvalid, rdata, init_val(32'h60));
    end
  endtask

  task automatic test_sft_rst();
    idle(2);
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 14'h100; i_req = 1; i_addr = 14'h061; #1;
    tests_run++;
    if (d_gnt !== 1'b1) begin
      failures++; $display("FAIL sft_pre_grant: got d_gnt=%b want 1", d_gnt);
    end
    @(negedge clk);
    sft_rst = 1; #1;
    tests_run++;
    if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || ram_cs !== 1'b0) begin
      failures++; $display("FAIL sft_no_grant: got i=%b d=%b cs=%b want 0 0 0", i_gnt, d_gnt, ram_cs);
    end
    @(posedge clk); #1;
    tests_run++;
    if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || dut.starve_cnt_q !== 3'd0) begin
      failures++; $display("FAIL sft_cleared: got d_rv=%b i_rv=%b cnt=%0d want 0 0 0", d_rvalid, i_rvalid, dut.starve_cnt_q);
    end
    @(negedge clk);
    sft_rst = 0; #1;
    tests_run++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || ram_cs !== 1'b1) begin
      failures++; $display("FAIL sft_resume: got d=%b i=%b cs=%b want 1 0 1", d_gnt, i_gnt, ram_cs);
    end
    @(negedge clk);
    d_req = 0; #1;
    tests_run++;
    if (d_rvalid !== 1'b1 || rdata !== 64'hDEADBEEF_CAFEF00D || i_gnt !== 1'b1) begin
      failures++; $display("FAIL sft_reissue: got d_rv=%b rdata=%h i_gnt=%b", d_rvalid, rdata, i_gnt);
    end
    idle(2);
  endtask

  task automatic test_random();
    bit            ip, dp, ev_i, ev_d;
    int            g;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] want_addr;
    ip = 0; dp = 0;
    idle(2);
    m_cnt = 0; exp_i = 0; exp_d = 0; exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      sft_rst = ($urandom_range(0, 99) < 3);
      if (!ip) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = AW'(32'h200 + $urandom_range(0, 31));
        ip     = i_req;
      end
      if (!dp) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_we    = $urandom_range(0, 1);
        d_addr  = AW'(32'h200 + $urandom_range(0, 31));
        d_wdata = {$urandom, $urandom};
        dp      = d_req;
      end
      #1;
      ev_i = exp_i && !sft_rst;
      ev_d = exp_d && !sft_rst;
      exp_data = '0;
      if (exp_i || exp_d) exp_data = exp_q.pop_front();
      tests_run++;
      if (i_rvalid !== ev_i || d_rvalid !== ev_d || ((ev_i || ev_d) && rdata !== exp_data)) begin
        failures++; $display("FAIL rand_resp%0d: got i_rv=%b d_rv=%b rdata=%h want %b %b %h", n, i_rvalid, d_rvalid, rdata, ev_i, ev_d, exp_data);
      end
      g = pick();
      want_addr = (g == 2) ? d_addr : ((g == 1) ? i_addr : '0);
      tests_run++;
      if (i_gnt !== (g == 1) || d_gnt !== (g == 2) || ram_cs !== (g != 0) ||
          ram_we !== (g == 2 && d_we) || ram_addr !== want_addr || int'(dut.starve_cnt_q) != m_cnt) begin
        failures++; $display("FAIL rand_grant%0d: got i=%b d=%b cs=%b we=%b addr=%h cnt=%0d want sel=%0d addr=%h cnt=%0d",
                             n, i_gnt, d_gnt, ram_cs, ram_we, ram_addr, dut.starve_cnt_q, g, want_addr, m_cnt);
      end
      commit(g);
      if (g == 1) ip = 0;
      if (g == 2) dp = 0;
    end
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; sft_rst = 0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_collision();
    test_sft_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
